latex_uart_tx: RTL and testbench
================================

Name: latex_uart_tx

Overview:
Downstream serial stage for the transform lookup path. It accepts the ASCII characters of a LaTeX function or transform string one byte at a time over a valid/ready handshake. Bytes are buffered in a small FIFO and sent as 8N1 UART frames. After a byte tagged as end-of-string, the block appends CR LF, so a host terminal shows one transform per line.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
FIFO_DEPTH, 4, entries in the input FIFO; power of two, at least 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data/in_last are valid this cycle
in_ready  output  1  FIFO can accept a byte this cycle
in_data  input  8  ASCII character
in_last  input  1  character ends a string; CR LF is appended after it
tx  output  1  UART serial line; idle high
busy  output  1  a frame, or a CR/LF suffix frame, is in progress
fifo_level  output  log2(FIFO_DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (asynchronous, takes effect immediately, mid-frame included):
  - tx=1, busy=0, fifo_level=0, in_ready=1.
  - FIFO is emptied and the FSM goes to IDLE; any partial frame is abandoned.
- FIFO:
  - Each entry is 9 bits {last,data}.
  - Push on a rising edge with in_valid && in_ready.
  - in_ready = (fifo_level != FIFO_DEPTH). It depends only on the registered level, not on a same-cycle pop.
  - A push and a pop in the same edge leave fifo_level unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Data is first-in first-out; no byte is dropped or duplicated.
- FSM states: IDLE, START, DATA, STOP.
  - A baud counter counts 0..CLKS_PER_BIT-1; each bit lasts exactly CLKS_PER_BIT cycles.
  - A bit counter counts 0..7 in DATA.
  - A suffix counter takes values NONE, CR, LF.
- IDLE:
  - tx=1, busy=0.
  - If the FIFO is non-empty at an edge: pop, load the shift register and last flag, enter START, drive tx=0 from that edge.
  - Latency: a byte pushed into an empty FIFO at edge N is popped at edge N+1, and tx falls at N+1.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - Eight bits, LSB first, each CLKS_PER_BIT cycles.
  - Shift right at each bit boundary.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the last stop-bit edge, in priority order:
  1. suffix NONE and latched last=1: load 0x0D, suffix=CR, enter START.
  2. suffix CR: load 0x0A, suffix=LF, enter START.
  3. Otherwise (suffix LF or no suffix pending): clear suffix. If the FIFO is non-empty, pop directly into START with no idle gap. Else go to IDLE.
- Frame period is exactly 10*CLKS_PER_BIT cycles; back-to-back frames have zero gap.
- Suffix frames never pop the FIFO. in_last of a suffix byte is ignored.
- busy=1 in START, DATA, STOP (suffix frames included); busy=0 only in IDLE.
- tx is driven from a register, glitch-free.

Test Plan:
1. CLKS_PER_BIT=4. Push 0x41 with last=0 into an empty block at edge N.
   -> Pop at N+1; tx low from N+1 for 4 cycles; then bits 1,0,0,0,0,0,1,0 at 4 cycles each; then 4 cycles high; IDLE at N+41; busy=1 from N+1 to N+40.
2. CLKS_PER_BIT=4. Push 0x80 then 0x01 on consecutive cycles.
   -> Two frames totalling 80 cycles with no gap between stop and start. Data bits are 00000001 then 10000000.
3. CLKS_PER_BIT=4. Push "s" (0x73) with last=1.
   -> Three frames 0x73, 0x0D, 0x0A, 120 cycles total; FIFO is untouched by the suffix frames.
4. Backpressure, FIFO_DEPTH=4. Hold in_valid=1 for 10 cycles.
   -> 5 bytes accepted (1 popped, 4 stored); in_ready low with fifo_level=4.
   -> in_ready rises at the edge that pops the next byte (end of the first stop bit).
   -> All 5 bytes transmitted in order.
5. Assert rst_n=0 mid-DATA with 2 bytes queued.
   -> tx=1, busy=0, fifo_level=0 immediately (asynchronously).
   -> After release, push 0x30: a clean single frame, no stale data.
6. Push last=1 then another byte during the CR frame.
   -> Output order is byte, 0x0D, 0x0A, new byte; the new byte pops only after LF's stop bit.

Source files
------------

// File: rtl/latex_uart_tx.sv
// rtl/latex_uart_tx.sv - 8N1 UART transmitter with input FIFO and CR LF appended after end-of-string bytes
module latex_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          in_last,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  typedef enum logic [1:0] {SUF_NONE, SUF_CR, SUF_LF} suffix_t;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, fifo_empty;
  logic [8:0]    head;

  state_t        state, state_n;
  suffix_t       suffix, suffix_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          last_q, last_n;
  logic          tx_q, tx_n;
  logic          baud_done;

  assign in_ready   = (fifo_level != LVL_FULL);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (fifo_level == '0);
  assign head       = mem[rd_ptr];
  assign baud_done  = (baud_cnt == BAUD_MAX);
  assign tx         = tx_q;
  assign busy       = (state != IDLE);

  // Storage has no reset; emptiness is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      suffix   <= SUF_NONE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      last_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      suffix   <= suffix_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      last_q   <= last_n;
      tx_q     <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    suffix_n = suffix;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    last_n   = last_q;
    tx_n     = tx_q;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = head[7:0];
          last_n  = head[8];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          baud_n = baud_cnt + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            bit_n   = bit_cnt + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          // Suffix frames take priority over the FIFO so CR LF stays glued to its string.
          if (suffix == SUF_NONE && last_q) begin
            shift_n  = 8'h0D;
            suffix_n = SUF_CR;
            last_n   = 1'b0;
            state_n  = START;
            tx_n     = 1'b0;
          end else if (suffix == SUF_CR) begin
            shift_n  = 8'h0A;
            suffix_n = SUF_LF;
            last_n   = 1'b0;
            state_n  = START;
            tx_n     = 1'b0;
          end else begin
            suffix_n = SUF_NONE;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_n = head[7:0];
              last_n  = head[8];
              state_n = START;
              tx_n    = 1'b0;
            end else begin
              state_n = IDLE;
              tx_n    = 1'b1;
            end
          end
        end else begin
          baud_n = baud_cnt + BAUD_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_latex_uart_tx.sv
// tb/tb_latex_uart_tx.sv - self-checking bench for latex_uart_tx with a UART receiver and byte-stream model
module tb_latex_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, tx, busy;
  logic [2:0] fifo_level;

  latex_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .tx(tx), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_acc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  bit         rx_ok[$];
  int         rx_start[$];
  int         starts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected line-stream: every accepted byte, followed by CR LF when it ends a string.
  task automatic model_push(input logic [7:0] d, input logic l);
    exp_q.push_back(d);
    if (l) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // Mid-bit sampling receiver on the negative edge.
  initial begin : receiver
    logic [7:0] b;
    bit ok;
    int s;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        s = cyc;
        ok = 1'b1;
        @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        repeat (CPB - 2) @(negedge clk);
        rx_data.push_back(b);
        rx_ok.push_back(ok);
        rx_start.push_back(s);
      end
    end
  end

  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [7:0] d, input logic l);
    bit acc;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    do begin
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 400);
    in_valid = 1'b0;
    last_acc = cyc;
    if (acc) model_push(d, l);
    else check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n, g;
    n = exp_q.size();
    g = 0;
    starts.delete();
    while ((rx_data.size() < n || busy) && g < n * 50 + 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_count"}, rx_data.size(), n);
    while (exp_q.size() > 0 && rx_data.size() > 0) begin
      check({tag, "_byte"}, rx_data.pop_front(), exp_q.pop_front());
      check({tag, "_framing"}, rx_ok.pop_front(), 1);
      starts.push_back(rx_start.pop_front());
    end
    exp_q.delete();
    rx_data.delete();
    rx_ok.delete();
    rx_start.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gaps(input string tag);
    for (int i = 1; i < starts.size(); i++)
      check(tag, starts[i] - starts[i-1], FRAME);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, a, acc_n, first_acc, k;
    logic etx, eb;
    logic [7:0] t1;
    bit ok;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, cycle-exact waveform for 0x41.
    t1 = 8'h41;
    send(t1, 1'b0);
    n = last_acc;
    for (int j = 0; j <= 41; j++) begin
      @(negedge clk);
      k = j - 1;
      if (j == 0 || j >= 41)    etx = 1'b1;
      else if (k < CPB)         etx = 1'b0;
      else if (k < 9 * CPB)     etx = t1[(k - CPB) / CPB];
      else                      etx = 1'b1;
      eb = (j >= 1 && j <= 40);
      check("t1_tx", tx, etx);
      check("t1_busy", busy, eb);
      if (j == 0) check("t1_level_pushed", fifo_level, 1);
      if (j == 1) check("t1_level_popped", fifo_level, 0);
    end
    drain("t1");

    // Back-to-back frames with zero gap.
    send(8'h80, 1'b0);
    send(8'h01, 1'b0);
    drain("t2");
    check("t2_frames", starts.size(), 2);
    check_gaps("t2_gap");

    // End-of-string suffix.
    send(8'h73, 1'b1);
    a = last_acc;
    wait_cyc(a + 1 + FRAME + 10);
    check("t3_level_in_suffix", fifo_level, 0);
    drain("t3");
    check("t3_frames", starts.size(), 3);
    check_gaps("t3_gap");

    // Backpressure with in_valid held for 10 cycles.
    acc_n = 0;
    first_acc = -1;
    in_valid = 1'b1;
    in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        model_push(in_data, 1'b0);
        acc_n++;
        if (first_acc < 0) first_acc = cyc;
      end
    end
    in_valid = 1'b0;
    check("t4_accepted", acc_n, 5);
    check("t4_ready_full", in_ready, 0);
    check("t4_level_full", fifo_level, 4);
    wait_cyc(first_acc + FRAME);
    check("t4_ready_before_pop", in_ready, 0);
    @(posedge clk);
    #1;
    check("t4_ready_after_pop", in_ready, 1);
    check("t4_level_after_pop", fifo_level, 3);
    drain("t4");
    check_gaps("t4_gap");

    // Asynchronous reset mid-DATA with two bytes queued.
    send(8'h31, 1'b0);
    a = last_acc;
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    wait_cyc(a + 1 + CPB + 6);
    check("t5_level_before", fifo_level, 2);
    check("t5_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_level", fifo_level, 0);
    check("t5_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    exp_q.delete();
    rx_data.delete();
    rx_ok.delete();
    rx_start.delete();
    send(8'h30, 1'b0);
    drain("t5");

    // New byte arrives during the CR frame; it must wait for LF.
    send(8'h55, 1'b1);
    a = last_acc;
    wait_cyc(a + 1 + FRAME + 5);
    send(8'h66, 1'b0);
    wait_cyc(a + 1 + 3 * FRAME - 1);
    check("t6_level_before_lf_end", fifo_level, 1);
    @(posedge clk);
    #1;
    check("t6_level_after_lf_end", fifo_level, 0);
    drain("t6");
    check_gaps("t6_gap");

    // Randomised strings with random idle gaps.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 80)) begin
        @(posedge clk);
        #1;
      end
      send(8'($urandom), ($urandom_range(0, 3) == 0));
    end
    drain("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
